// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline control bundle between the hazard/event sources and the stall controller.
// The controller takes the slave side: it consumes events and drives hold/flush/bubble enables.
interface pipe_stall_ctrl_if;
    logic ld_use_rs;
    logic ld_use_rt;
    logic dmem_busy;
    logic imem_busy;
    logic br_taken;
    logic halt_id;
    logic halt_wb;

    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_hold;
    logic exmem_hold;
    logic exmem_bubble;
    logic memwb_bubble;

    modport master (
        output ld_use_rs, ld_use_rt, dmem_busy, imem_busy, br_taken, halt_id, halt_wb,
        input  pc_hold, ifid_hold, ifid_flush, idex_hold, exmem_hold, exmem_bubble, memwb_bubble
    );

    modport slave (
        input  ld_use_rs, ld_use_rt, dmem_busy, imem_busy, br_taken, halt_id, halt_wb,
        output pc_hold, ifid_hold, ifid_flush, idex_hold, exmem_hold, exmem_bubble, memwb_bubble
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: halt-drain FSM, dmem wait watchdog
// and saturating stall/flush performance counters.
//
// state  | meaning
// RUN    | normal operation, hazards resolved by priority
// DRAIN  | HALT seen in ID, fetch frozen while older instructions retire
// HALTED | HALT retired, whole pipe frozen until reset
// ERR    | dmem watchdog expired, whole pipe frozen until reset
module pipe_stall_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  pipe,
    output logic              halted,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        ERR    = 2'd3
    } stateT;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    stateT            state;
    stateT            nextState;
    logic [7:0]       waitCnt;
    logic             ldUse;
    logic             frozen;
    logic             timeout;
    logic             pcHold;
    logic             ifidHold;
    logic             ifidFlush;
    logic             idexHold;
    logic             exmemHold;
    logic             exmemBubble;
    logic             memwbBubble;
    logic             haltedQ;
    logic             errQ;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    assign ldUse  = pipe.ld_use_rs | pipe.ld_use_rt;
    assign frozen = (state == HALTED) || (state == ERR);
    // Timeout fires on the MAX_WAIT-th consecutive busy cycle.
    assign timeout = pipe.dmem_busy && (waitCnt == WAIT_LAST);

    always_comb begin
        pcHold      = 1'b0;
        ifidHold    = 1'b0;
        ifidFlush   = 1'b0;
        idexHold    = 1'b0;
        exmemHold   = 1'b0;
        exmemBubble = 1'b0;
        memwbBubble = 1'b0;
        if (frozen || pipe.dmem_busy) begin
            pcHold      = 1'b1;
            ifidHold    = 1'b1;
            idexHold    = 1'b1;
            exmemHold   = 1'b1;
            memwbBubble = 1'b1;
        end else if (ldUse) begin
            pcHold      = 1'b1;
            ifidHold    = 1'b1;
            idexHold    = 1'b1;
            exmemBubble = 1'b1;
        end else if (state == DRAIN) begin
            pcHold    = 1'b1;
            ifidFlush = 1'b1;
        end else if (pipe.imem_busy || pipe.br_taken) begin
            // A taken branch must load its target even with a fetch outstanding.
            ifidFlush = 1'b1;
            pcHold    = pipe.imem_busy & ~pipe.br_taken;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            RUN: begin
                if (timeout)
                    nextState = ERR;
                else if (pipe.halt_wb)
                    nextState = HALTED;
                else if (pipe.halt_id && !pipe.dmem_busy && !ldUse)
                    nextState = DRAIN;
            end
            DRAIN: begin
                if (timeout)
                    nextState = ERR;
                else if (pipe.halt_wb)
                    nextState = HALTED;
            end
            HALTED:  nextState = HALTED;
            ERR:     nextState = ERR;
            default: nextState = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= nextState;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt  <= 8'd0;
            haltedQ  <= 1'b0;
            errQ     <= 1'b0;
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (!pipe.dmem_busy)
                waitCnt <= 8'd0;
            else if (waitCnt != 8'hFF)
                waitCnt <= waitCnt + 8'd1;
            haltedQ <= (nextState == HALTED);
            errQ    <= errQ | (nextState == ERR);
            if (!frozen && pcHold && (stallCnt != '1))
                stallCnt <= stallCnt + CNT_W'(1);
            if (!frozen && ifidFlush && (flushCnt != '1))
                flushCnt <= flushCnt + CNT_W'(1);
        end
    end

    assign pipe.pc_hold      = pcHold;
    assign pipe.ifid_hold    = ifidHold;
    assign pipe.ifid_flush   = ifidFlush;
    assign pipe.idex_hold    = idexHold;
    assign pipe.exmem_hold   = exmemHold;
    assign pipe.exmem_bubble = exmemBubble;
    assign pipe.memwb_bubble = memwbBubble;

    assign halted       = haltedQ;
    assign err_timeout  = errQ;
    assign stall_cycles = stallCnt;
    assign flush_count  = flushCnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a CNT_W=16 instance for function and a
// CNT_W=4 twin sharing its inputs to exercise counter saturation.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl_if bus ();
    pipe_stall_ctrl_if satBus ();

    logic        halted, errTimeout;
    logic [15:0] stallCycles, flushCount;
    logic        satHalted, satErr;
    logic [3:0]  satStall, satFlush;

    pipe_stall_ctrl #(.CNT_W(16), .MAX_WAIT(32)) dut (
        .clk(clk), .rst(rst), .pipe(bus),
        .halted(halted), .err_timeout(errTimeout),
        .stall_cycles(stallCycles), .flush_count(flushCount)
    );

    pipe_stall_ctrl #(.CNT_W(4), .MAX_WAIT(32)) satDut (
        .clk(clk), .rst(rst), .pipe(satBus),
        .halted(satHalted), .err_timeout(satErr),
        .stall_cycles(satStall), .flush_count(satFlush)
    );

    assign satBus.ld_use_rs = bus.ld_use_rs;
    assign satBus.ld_use_rt = bus.ld_use_rt;
    assign satBus.dmem_busy = bus.dmem_busy;
    assign satBus.imem_busy = bus.imem_busy;
    assign satBus.br_taken  = bus.br_taken;
    assign satBus.halt_id   = bus.halt_id;
    assign satBus.halt_wb   = bus.halt_wb;

    // {pc_hold, ifid_hold, ifid_flush, idex_hold, exmem_hold, exmem_bubble, memwb_bubble}
    logic [6:0] outs;
    assign outs = {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_hold,
                   bus.exmem_hold, bus.exmem_bubble, bus.memwb_bubble};

    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_FREEZE = 7'b1101101;
    localparam logic [6:0] O_LDUSE = 7'b1101010;
    localparam logic [6:0] O_DRAIN = 7'b1010000;
    localparam logic [6:0] O_FLUSH = 7'b0010000;

    // input vector: {rs, rt, dmem, imem, br, halt_id, halt_wb}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_RS   = 7'b1000000;
    localparam logic [6:0] I_RT   = 7'b0100000;
    localparam logic [6:0] I_DMEM = 7'b0010000;
    localparam logic [6:0] I_IMEM = 7'b0001000;
    localparam logic [6:0] I_BR   = 7'b0000100;
    localparam logic [6:0] I_HID  = 7'b0000010;
    localparam logic [6:0] I_HWB  = 7'b0000001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs just after the falling edge; checks follow before the next rise.
    task automatic cyc(input logic [6:0] v);
        @(negedge clk);
        {bus.ld_use_rs, bus.ld_use_rt, bus.dmem_busy, bus.imem_busy,
         bus.br_taken, bus.halt_id, bus.halt_wb} = v;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        {bus.ld_use_rs, bus.ld_use_rt, bus.dmem_busy, bus.imem_busy,
         bus.br_taken, bus.halt_id, bus.halt_wb} = I_NONE;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        {bus.ld_use_rs, bus.ld_use_rt, bus.dmem_busy, bus.imem_busy,
         bus.br_taken, bus.halt_id, bus.halt_wb} = I_NONE;
        repeat (2) @(posedge clk);
        doReset();
        chk("reset_outs", 32'(outs), 32'(O_NONE));
        chk("reset_stall", 32'(stallCycles), 0);
        chk("reset_flush", 32'(flushCount), 0);
        chk("reset_halted", 32'(halted), 0);
        chk("reset_err", 32'(errTimeout), 0);

        // single load-use stall
        cyc(I_RT);
        chk("lduse_rt_outs", 32'(outs), 32'(O_LDUSE));
        cyc(I_NONE);
        chk("lduse_release_outs", 32'(outs), 32'(O_NONE));
        chk("lduse_stall", 32'(stallCycles), 1);
        chk("lduse_flush", 32'(flushCount), 0);

        // branch overrides pending fetch, then fetch stall alone
        cyc(I_BR | I_IMEM);
        chk("br_imem_outs", 32'(outs), 32'(O_FLUSH));
        cyc(I_IMEM);
        chk("imem_outs", 32'(outs), 32'(O_DRAIN));
        chk("br_flush", 32'(flushCount), 1);
        chk("br_stall", 32'(stallCycles), 1);
        cyc(I_NONE);
        chk("imem_flush", 32'(flushCount), 2);
        chk("imem_stall", 32'(stallCycles), 2);

        // dmem busy dominates load-use and branch
        for (int i = 0; i < 3; i++) begin
            cyc(I_DMEM | I_RS | I_BR);
            chk("dmem_prio_outs", 32'(outs), 32'(O_FREEZE));
        end
        cyc(I_RS);
        chk("lduse_after_dmem_outs", 32'(outs), 32'(O_LDUSE));
        chk("dmem_stall", 32'(stallCycles), 5);
        cyc(I_NONE);
        chk("dmem_flush", 32'(flushCount), 2);
        chk("lduse2_stall", 32'(stallCycles), 6);

        // halt drain: halt_id, two quiet drain cycles, halt_wb on the third
        cyc(I_HID);
        chk("halt_id_outs", 32'(outs), 32'(O_NONE));
        cyc(I_NONE);
        chk("drain1_outs", 32'(outs), 32'(O_DRAIN));
        cyc(I_NONE);
        chk("drain2_outs", 32'(outs), 32'(O_DRAIN));
        cyc(I_HWB);
        chk("drain3_outs", 32'(outs), 32'(O_DRAIN));
        chk("drain3_halted", 32'(halted), 0);
        cyc(I_NONE);
        chk("halted_outs", 32'(outs), 32'(O_FREEZE));
        chk("halted_flag", 32'(halted), 1);
        chk("halted_stall", 32'(stallCycles), 9);
        chk("halted_flush", 32'(flushCount), 5);
        cyc(I_BR | I_IMEM | I_HID);
        chk("halted_hold_outs", 32'(outs), 32'(O_FREEZE));
        cyc(I_NONE);
        chk("halted_frozen_stall", 32'(stallCycles), 9);
        chk("halted_frozen_flush", 32'(flushCount), 5);
        chk("halted_sticky", 32'(halted), 1);

        // reset out of HALTED
        doReset();
        chk("rst_halted_flag", 32'(halted), 0);
        chk("rst_halted_outs", 32'(outs), 32'(O_NONE));
        chk("rst_halted_stall", 32'(stallCycles), 0);

        // watchdog: 40 busy cycles, timeout after the 32nd
        for (int i = 1; i <= 40; i++) begin
            cyc(I_DMEM);
            chk("wd_outs", 32'(outs), 32'(O_FREEZE));
            if (i == 32) begin
                chk("wd_err_before", 32'(errTimeout), 0);
                chk("wd_stall_before", 32'(stallCycles), 31);
            end
            if (i == 33) begin
                chk("wd_err_after", 32'(errTimeout), 1);
                chk("wd_stall_at", 32'(stallCycles), 32);
            end
        end
        cyc(I_NONE);
        chk("err_outs", 32'(outs), 32'(O_FREEZE));
        chk("err_sticky", 32'(errTimeout), 1);
        chk("err_frozen_stall", 32'(stallCycles), 32);
        chk("err_frozen_flush", 32'(flushCount), 0);
        chk("err_not_halted", 32'(halted), 0);
        doReset();
        chk("rst_err_flag", 32'(errTimeout), 0);
        chk("rst_err_stall", 32'(stallCycles), 0);
        chk("rst_err_outs", 32'(outs), 32'(O_NONE));

        // saturation on the narrow twin
        for (int i = 0; i < 20; i++) cyc(I_RT);
        cyc(I_NONE);
        chk("sat_stall", 32'(satStall), 15);
        chk("wide_stall", 32'(stallCycles), 20);

        // halt_id during load-use is ignored; halt_wb goes straight to HALTED
        cyc(I_HID | I_RT);
        chk("hid_lduse_outs", 32'(outs), 32'(O_LDUSE));
        cyc(I_NONE);
        chk("hid_ignored_outs", 32'(outs), 32'(O_NONE));
        cyc(I_HWB);
        chk("hwb_run_outs", 32'(outs), 32'(O_NONE));
        cyc(I_NONE);
        chk("hwb_run_halted", 32'(halted), 1);
        chk("hwb_run_frozen", 32'(outs), 32'(O_FREEZE));

        // timeout and halt_wb in the same cycle: ERR wins
        doReset();
        for (int i = 0; i < 31; i++) cyc(I_DMEM);
        cyc(I_DMEM | I_HWB);
        cyc(I_NONE);
        chk("err_prio_err", 32'(errTimeout), 1);
        chk("err_prio_halted", 32'(halted), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
